// File: rtl/i2s_mic_receiver.sv
// I2S master receiver: generates SCK/WS for an I2S MEMS microphone and
// deserialises one slot of SD into a one-entry valid/ready sample buffer.
module i2s_mic_receiver #(
    parameter int CLK_DIV     = 16,
    parameter int SAMPLE_BITS = 18,
    parameter int CHANNEL     = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   SD,
    output logic                   SCK,
    output logic                   WS,
    output logic [SAMPLE_BITS-1:0] sample_data,
    output logic                   sample_valid,
    input  logic                   sample_ready,
    output logic                   overrun
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [5:0] SLOT_FIRST = 6'(CHANNEL * 32 + 1);
    localparam logic [5:0] SLOT_LAST  = 6'(CHANNEL * 32 + SAMPLE_BITS);

    logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
    logic                   sck_q, sck_d;
    logic [5:0]             bit_cnt_q, bit_cnt_d;
    logic                   ws_q, ws_d;
    logic [SAMPLE_BITS-1:0] shift_q, shift_d;
    logic [SAMPLE_BITS-1:0] data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ovr_q, ovr_d;

    logic                   tick;
    logic                   rise;
    logic                   fall;
    logic                   in_slot;
    logic                   load;
    logic [SAMPLE_BITS-1:0] shifted;

    always_comb begin
        tick = (div_cnt_q == DIV_LAST);
        rise = tick & ~sck_q;
        fall = tick & sck_q;

        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
        sck_d     = sck_q ^ tick;

        bit_cnt_d = bit_cnt_q;
        if (fall) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
        end
        // WS follows the post-increment count so it moves with the SCK fall
        ws_d = bit_cnt_d[5];
    end

    always_comb begin
        in_slot = (bit_cnt_q >= SLOT_FIRST) && (bit_cnt_q <= SLOT_LAST);
        load    = rise && (bit_cnt_q == SLOT_LAST);
        shifted = (shift_q << 1) | SAMPLE_BITS'(SD);

        shift_d = shift_q;
        if (rise && in_slot) begin
            shift_d = shifted;
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (load) begin
            data_d  = shifted;
            valid_d = 1'b1;
            // A same-edge accept consumes the old sample, so no overrun
            if (valid_q && !sample_ready) begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt_q <= '0;
            sck_q     <= 1'b0;
            bit_cnt_q <= 6'd63;
            ws_q      <= 1'b1;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            sck_q     <= sck_d;
            bit_cnt_q <= bit_cnt_d;
            ws_q      <= ws_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
        end
    end

    assign SCK          = sck_q;
    assign WS           = ws_q;
    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_i2s_mic_receiver.sv
// Bench for i2s_mic_receiver: left and right receivers share one mic line,
// checked every cycle against a timing/frame model plus literal spot checks.
module tb_i2s_mic_receiver;

    localparam int D  = 2;
    localparam int SB = 18;

    localparam logic [17:0] TL [8] = '{
        18'h2A5C3, 18'h0F00F, 18'h1FFFF, 18'h3FFFF,
        18'h20000, 18'h12345, 18'h0ABCD, 18'h3C3C3};
    localparam logic [17:0] TR [8] = '{
        18'h3FFFF, 18'h20000, 18'h00000, 18'h15555,
        18'h2AAAA, 18'h3FFFE, 18'h00001, 18'h1E1E1};

    logic          clk = 1'b0;
    logic          reset;
    logic          sd;
    logic          rdy0;
    logic          rdy1;
    logic [1:0]    sck;
    logic [1:0]    ws;
    logic [SB-1:0] data [2];
    logic [1:0]    valid;
    logic [1:0]    ovr;

    int n_checks = 0;
    int n_errs   = 0;
    int t        = 0;
    int fbase    = 0;
    int ep       = 0;
    bit started  = 0;

    bit            ev [2];
    bit            eo [2];
    logic [SB-1:0] ed [2];

    always #5 clk = ~clk;

    i2s_mic_receiver #(.CLK_DIV(D), .SAMPLE_BITS(SB), .CHANNEL(0)) u_left (
        .clk(clk), .reset(reset), .SD(sd), .SCK(sck[0]), .WS(ws[0]),
        .sample_data(data[0]), .sample_valid(valid[0]),
        .sample_ready(rdy0), .overrun(ovr[0]));

    i2s_mic_receiver #(.CLK_DIV(D), .SAMPLE_BITS(SB), .CHANNEL(1)) u_right (
        .clk(clk), .reset(reset), .SD(sd), .SCK(sck[1]), .WS(ws[1]),
        .sample_data(data[1]), .sample_valid(valid[1]),
        .sample_ready(rdy1), .overrun(ovr[1]));

    // frame number of the frame in progress after tt clock edges
    function automatic int fid(input int tt);
        return fbase + (tt / (2 * D) + 63) / 64;
    endfunction

    function automatic int bitpos(input int tt);
        return (63 + tt / (2 * D)) % 64;
    endfunction

    function automatic logic [17:0] word(input int ch, input int id);
        if (ch == 0) return TL[(id - 1) % 8];
        return TR[(id - 1) % 8];
    endfunction

    function automatic logic mic_bit();
        int b;
        int id;
        logic [17:0] w;
        b  = bitpos(t);
        id = fid(t);
        if (id < 1) return 1'b1;
        if (b >= 1 && b <= SB) begin
            w = TL[(id - 1) % 8];
            return w[SB - b];
        end
        if (b >= 33 && b <= 32 + SB) begin
            w = TR[(id - 1) % 8];
            return w[32 + SB - b];
        end
        return (b % 3) == 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s ep=%0d t=%0d: got %0h expected %0h",
                     nm, ep, t, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            fbase = fid(t);
            t = 0;
            for (int i = 0; i < 2; i++) begin
                ev[i] = 0;
                eo[i] = 0;
                ed[i] = '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit ld;
                bit rd;
                rd = (i == 0) ? rdy0 : rdy1;
                ld = (t % (2 * D) == D - 1) && (bitpos(t) == i * 32 + SB);
                if (ld) begin
                    if (ev[i] && !rd) eo[i] = 1;
                    ed[i] = word(i, fid(t));
                    ev[i] = 1;
                end else if (ev[i] && rd) begin
                    ev[i] = 0;
                end
            end
            t++;
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                chk("sck", 32'(sck[i]), 32'((t / D) % 2));
                chk("ws", 32'(ws[i]), 32'(bitpos(t) >= 32));
                chk("valid", 32'(valid[i]), 32'(ev[i]));
                chk("overrun", 32'(ovr[i]), 32'(eo[i]));
                chk("data", 32'(data[i]), 32'(ed[i]));
            end
            if (ep == 0 && t == 3) begin
                chk("lit_sck_t3", 32'(sck[0]), 32'd1);
                chk("lit_ws_t3", 32'(ws[0]), 32'd1);
            end
            if (ep == 0 && t == 4) begin
                chk("lit_sck_t4", 32'(sck[0]), 32'd0);
                chk("lit_ws_t4", 32'(ws[0]), 32'd0);
            end
            if (ep == 0 && t == 131) chk("lit_ws_low_end", 32'(ws[0]), 32'd0);
            if (ep == 0 && t == 132) chk("lit_ws_high", 32'(ws[0]), 32'd1);
            if (ep == 0 && t == 77) chk("lit_l_pre", 32'(valid[0]), 32'd0);
            if (ep == 0 && t == 78) begin
                chk("lit_l_valid", 32'(valid[0]), 32'd1);
                chk("lit_l_data", 32'(data[0]), 32'h2A5C3);
            end
            if (ep == 0 && t == 205) chk("lit_r_pre", 32'(valid[1]), 32'd0);
            if (ep == 0 && t == 206) begin
                chk("lit_r_valid", 32'(valid[1]), 32'd1);
                chk("lit_r_data", 32'(data[1]), 32'h3FFFF);
            end
            if (ep == 0 && t == 462) begin
                chk("lit_r_neg", 32'(data[1]), 32'h20000);
                chk("lit_r_ovr", 32'(ovr[1]), 32'd0);
            end
            if (ep == 0 && t == 250) chk("lit_hold", 32'(valid[0]), 32'd1);
            if (ep == 0 && t == 251) chk("lit_drop", 32'(valid[0]), 32'd0);
            if (ep == 0 && t == 334) chk("lit_reload", 32'(valid[0]), 32'd1);
            if (ep == 0 && t == 589) chk("lit_ovr_pre", 32'(ovr[0]), 32'd0);
            if (ep == 0 && t == 590) chk("lit_ovr_set", 32'(ovr[0]), 32'd1);
            if (ep == 0 && t == 846) chk("lit_newest", 32'(data[0]), 32'h3FFFF);
            if (ep == 0 && t == 1000) chk("lit_sticky", 32'(ovr[0]), 32'd1);
            if (ep == 1 && t == 0) begin
                chk("lit_rst_sck", 32'(sck[0]), 32'd0);
                chk("lit_rst_ws", 32'(ws[0]), 32'd1);
                chk("lit_rst_valid", 32'(valid[0]), 32'd0);
                chk("lit_rst_ovr", 32'(ovr[0]), 32'd0);
            end
            if (ep == 1 && t == 78) begin
                chk("lit_full_frame", 32'(data[0]), 32'h12345);
                chk("lit_full_valid", 32'(valid[0]), 32'd1);
            end
            if (ep == 1 && t == 334) begin
                chk("lit_same_edge_ovr", 32'(ovr[0]), 32'd0);
                chk("lit_same_edge_valid", 32'(valid[0]), 32'd1);
                chk("lit_same_edge_data", 32'(data[0]), 32'h0ABCD);
            end
        end
    end

    initial begin
        sd   = 1'b1;
        rdy1 = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            sd   = mic_bit();
            rdy1 = (ep == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic wait_t(input int target);
        int g;
        g = 0;
        while (t != target && g < 3000) begin
            @(posedge clk);
            #1;
            g++;
        end
        n_checks++;
        if (t != target) begin
            n_errs++;
            $display("FAIL wait_t timeout: got t=%0d expected %0d", t, target);
        end
    endtask

    initial begin
        int g;
        reset = 1'b0;
        rdy0  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        wait_t(250);
        rdy0 = 1'b1;
        wait_t(251);
        rdy0 = 1'b0;

        wait_t(900);
        g = 0;
        while (bitpos(t) != 10 && g < 400) begin
            @(posedge clk);
            #1;
            g++;
        end
        n_checks++;
        if (bitpos(t) != 10) begin
            n_errs++;
            $display("FAIL wait_bit10 timeout: got %0d expected 10", bitpos(t));
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        ep    = 1;

        wait_t(333);
        rdy0 = 1'b1;
        wait_t(334);
        rdy0 = 1'b0;
        wait_t(400);
        rdy0 = 1'b1;
        wait_t(1100);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/i2s_mic_receiver.md
# i2s_mic_receiver

I2S master receiver for the spectrometer front end. It generates SCK and WS for an external 18-bit I2S MEMS microphone, or for `i2sMicSim` in simulation, and deserialises SD into signed samples. Each sample is presented on a one-entry valid/ready output buffer that the FFT/windowing stage inside `spectroTOP2` consumes. The block owns the I2S clocking; nothing upstream drives SCK or WS.

## Interface
- `CLK_DIV`, 16: clk cycles per SCK half-period; must be ≥ 2.
- `SAMPLE_BITS`, 18: valid data bits per slot, MSB first; range 1..31.
- `CHANNEL`, 0: slot captured; 0 = left (WS low), 1 = right (WS high).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low reset.
- `SD` in 1: serial data from the microphone.
- `SCK` out 1: bit clock, registered.
- `WS` out 1: word select, registered.
- `sample_data` out SAMPLE_BITS: captured sample, two's complement.
- `sample_valid` out 1: `sample_data` holds an unconsumed sample.
- `sample_ready` in 1: consumer accepts the sample.
- `overrun` out 1: sticky flag; an unconsumed sample was overwritten.

## Operation
**SCK generation**
- `div_cnt` counts 0..CLK_DIV-1 and wraps.
- When `div_cnt==CLK_DIV-1`, SCK toggles.
- A 0→1 toggle is the internal strobe `rise`; a 1→0 toggle is `fall`.

**Frame counter**
- 6-bit `bit_cnt` increments on `fall` and wraps 63→0.
- WS = `bit_cnt[5]`, registered, so it updates on the same edge as SCK falls. Frame = 64 SCK periods; WS is low for bits 0–31 and high for bits 32–63.

**Capture**
- Define `off = CHANNEL*32`.
- On each `rise` with `bit_cnt` in `off+1 .. off+SAMPLE_BITS`, shift SD into the LSB of a SAMPLE_BITS shift register. The MSB arrives one SCK after the WS transition, per I2S.
- SD is sampled at the clk edge on which SCK goes high. SD was driven at the previous SCK fall, CLK_DIV clks earlier, so no synchroniser is needed.
- `load` strobe: a `rise` with `bit_cnt==off+SAMPLE_BITS`.
- On `load`, `sample_data` ← {shift[SAMPLE_BITS-2:0], SD} and `sample_valid` ← 1.
- Slot bits beyond SAMPLE_BITS and the other channel's slot are ignored.

**Output buffer** (priority at each clk edge)
1. `load`: overwrite `sample_data` and set `sample_valid`=1. If `sample_valid` was 1 and `sample_ready`=0, set `overrun`←1. If `sample_ready`=1 on the same edge, the old sample counts as consumed and `overrun` is not set.
2. No `load`, and `sample_valid`&`sample_ready`: clear `sample_valid`.
3. Otherwise hold.
- `overrun` clears only on reset.

**Reset**, while `reset`=0 at the clk edge:
- `div_cnt`=0, SCK=0, `bit_cnt`=63, WS=1.
- Shift register = 0, `sample_data`=0, `sample_valid`=0, `overrun`=0.

Reset asserted mid-frame aborts the frame; the partially shifted word is discarded.

## Timing
- First SCK rise: internal strobe at clk cycle CLK_DIV-1 after reset release; SCK reads 1 from cycle CLK_DIV.
- First `fall`: `bit_cnt` 63→0 and WS 1→0, giving a clean left-slot start.
- Rise k occurs 2·CLK_DIV·k + CLK_DIV-1 cycles after reset release.
- Default frame = 128·CLK_DIV clks (2048); sample rate = f_clk / (128·CLK_DIV).
- `load` occurs on the rise while `bit_cnt==off+SAMPLE_BITS`. `sample_valid` reads 1 the next cycle, which is zero added latency after the LSB edge.
- `sample_ready` is sampled only when `sample_valid`=1. Clearing is registered: `sample_valid` drops the cycle after acceptance.
- SCK and WS never glitch; both are direct register outputs.

## Test plan
1. **Clock generation** (CLK_DIV=2, reset released at t=0): SCK period is 4 clks; WS low for 128 clks, then high for 128 clks. The first WS fall coincides with the first SCK fall at cycle 3.
2. **Left capture** (CLK_DIV=2, CHANNEL=0): mic model drives 18'h2A5C3 in the left slot and 18'h3FFFF in the right slot. `sample_data`=18'h2A5C3 and `sample_valid`=1 the cycle after rise with `bit_cnt`=18; the right slot is ignored.
3. **Right capture and sign** (CHANNEL=1): right slot drives 18'h20000. Output is 18'h20000 (−131072), `sample_valid` appears after the rise at `bit_cnt`=50, and `overrun` stays 0.
4. **Handshake** (`sample_ready`=0 for 1 frame, then pulsed for 1 cycle): `sample_valid` holds 1 until the pulse and drops the following cycle. The next frame's `load` sets it again.
5. **Overrun:**
   - `sample_ready` held 0 for 3 frames: `sample_data` tracks the newest sample and `overrun`=1 from the second `load`.
   - `sample_ready`=1 exactly on a `load` edge: `overrun` stays 0.
6. **Mid-frame reset:** `reset`=0 for 1 cycle at `bit_cnt`=10. SCK=0, WS=1, `sample_valid`=0 and `overrun`=0 the next cycle. The next sample emitted is the complete following frame, never a partial word.
